// File: rtl/ascon_round_ctrl_pkg.sv
// Shared types and constants for the ASCON permutation round sequencer.
// round_t is also consumed by the constant-addition block.
package ascon_round_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} type_round_state;

    typedef logic [3:0] round_t;

    localparam round_t ROUND_LAST = 4'd11;
    localparam int     ROUNDS_A   = 12;
    localparam int     ROUNDS_B   = 6;

    // Rounds always finish at index 11, so shorter permutations start later.
    function automatic round_t start_index(input int rounds);
        return round_t'(int'(ROUND_LAST) + 1 - rounds);
    endfunction

endpackage

// File: rtl/ascon_round_ctrl_if.sv
// Handshake and datapath-control bundle between the ASCON top FSM (master)
// and the round sequencer (slave).
interface ascon_round_ctrl_if;
    import ascon_round_ctrl_pkg::*;

    logic   start_i;
    logic   mode_i;
    logic   ready_o;
    logic   input_select_o;
    logic   en_reg_state_o;
    round_t round_o;
    logic   busy_o;
    logic   done_o;

    modport master (
        output start_i, mode_i,
        input  ready_o, input_select_o, en_reg_state_o, round_o, busy_o, done_o
    );

    modport slave (
        input  start_i, mode_i,
        output ready_o, input_select_o, en_reg_state_o, round_o, busy_o, done_o
    );

endinterface

// File: rtl/ascon_round_ctrl_round_counter.sv
// 4-bit round index counter with synchronous load and increment.
// Load takes priority over increment.
module round_counter
    import ascon_round_ctrl_pkg::*;
(
    input  logic   clock_i,
    input  logic   resetb_i,
    input  logic   load_en,
    input  round_t load_value,
    input  logic   inc_en,
    output round_t count
);

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count <= '0;
        end else if (load_en) begin
            count <= load_value;
        end else if (inc_en) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/ascon_round_ctrl.sv
// Moore sequencer for the ASCON p^a / p^b permutation: drives the state mux
// select, state-register enable and round index, and pulses done on completion.
module ascon_round_ctrl #(
    parameter int ROUNDS_A = ascon_round_ctrl_pkg::ROUNDS_A,
    parameter int ROUNDS_B = ascon_round_ctrl_pkg::ROUNDS_B
) (
    input  logic                  clock_i,
    input  logic                  resetb_i,
    ascon_round_ctrl_if.slave     ctrl
);
    import ascon_round_ctrl_pkg::*;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FIRST = FIRST;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DONE  = DONE;

    localparam round_t START_A = start_index(ROUNDS_A);
    localparam round_t START_B = start_index(ROUNDS_B);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       mode_q;
    round_t     round;
    logic       last;
    logic       active;
    logic       load_en;

    assign last    = (round == ROUND_LAST);
    assign active  = (state == S_FIRST) || (state == S_RUN);
    assign load_en = (state == S_IDLE) && ctrl.start_i;

    round_counter u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_en    (load_en),
        .load_value (ctrl.mode_i ? START_A : START_B),
        .inc_en     (active && !last),
        .count      (round)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:        if (ctrl.start_i) state_next = S_FIRST;
            S_FIRST, S_RUN: state_next = last ? S_DONE : S_RUN;
            S_DONE:        state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
        end else begin
            state <= state_next;
            if (load_en) begin
                mode_q <= ctrl.mode_i;
            end
        end
    end

    // The first round must always use the start index of the latched mode.
    assert property (@(posedge clock_i) disable iff (!resetb_i)
        (state == S_FIRST) |-> (round == (mode_q ? START_A : START_B)));

    assign ctrl.ready_o        = (state == S_IDLE);
    assign ctrl.input_select_o = (state == S_FIRST);
    assign ctrl.en_reg_state_o = active;
    assign ctrl.busy_o         = active;
    assign ctrl.done_o         = (state == S_DONE);
    assign ctrl.round_o        = round;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl: vector table of p^a/p^b cycles
// plus hand-written reset, ignored-start, back-to-back and ROUNDS_B=1 sequences.
module tb_ascon_round_ctrl;

    typedef struct {
        logic       mode;
        int         cyc;
        logic       ready;
        logic       sel;
        logic       en;
        logic       busy;
        logic       done;
        logic [3:0] round;
        logic       round_care;
    } vec_t;

    logic clock;
    logic resetb;
    int   checks;
    int   errors;

    ascon_round_ctrl_if bus ();
    ascon_round_ctrl_if bus_b1 ();

    ascon_round_ctrl dut (
        .clock_i  (clock),
        .resetb_i (resetb),
        .ctrl     (bus)
    );

    ascon_round_ctrl #(.ROUNDS_A(12), .ROUNDS_B(1)) dut_b1 (
        .clock_i  (clock),
        .resetb_i (resetb),
        .ctrl     (bus_b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic mode);
        bus.start_i = start;
        bus.mode_i  = mode;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!bus.ready_o && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_ready: got timeout, expected ready within 60 cycles");
        end
    endtask

    // Leaves the bench in cycle 1 of the new permutation.
    task automatic startRun(input logic mode);
        waitReady();
        applyStimulus(1'b1, mode);
        tick();
        applyStimulus(1'b0, 1'b0);
    endtask

    vec_t vecs[13];

    initial begin
        logic [7:0] done1;
        logic [7:0] done2;

        checks = 0;
        errors = 0;
        applyStimulus(1'b0, 1'b0);
        bus_b1.start_i = 1'b0;
        bus_b1.mode_i  = 1'b0;

        //               mode cyc rdy sel en busy done round care
        vecs[0]  = '{1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd6,  1'b1};
        vecs[1]  = '{1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7,  1'b1};
        vecs[2]  = '{1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8,  1'b1};
        vecs[3]  = '{1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10, 1'b1};
        vecs[4]  = '{1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd11, 1'b1};
        vecs[5]  = '{1'b0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0};
        vecs[6]  = '{1'b0, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
        vecs[7]  = '{1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b1};
        vecs[8]  = '{1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1,  1'b1};
        vecs[9]  = '{1'b1, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6,  1'b1};
        vecs[10] = '{1'b1, 12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd11, 1'b1};
        vecs[11] = '{1'b1, 13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0};
        vecs[12] = '{1'b1, 14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};

        // Power-on reset state of both instances.
        resetb = 1'b0;
        #12;
        checkOutput("reset_ready",  {7'd0, bus.ready_o}, 8'd1);
        checkOutput("reset_busy",   {7'd0, bus.busy_o}, 8'd0);
        checkOutput("reset_done",   {7'd0, bus.done_o}, 8'd0);
        checkOutput("reset_sel",    {7'd0, bus.input_select_o}, 8'd0);
        checkOutput("reset_en",     {7'd0, bus.en_reg_state_o}, 8'd0);
        checkOutput("reset_round",  {4'd0, bus.round_o}, 8'd0);
        checkOutput("reset_b1_rdy", {7'd0, bus_b1.ready_o}, 8'd1);
        tick();
        resetb = 1'b1;
        tick();

        // Table-driven single-cycle observations.
        for (int i = 0; i < 13; i++) begin
            startRun(vecs[i].mode);
            repeat (vecs[i].cyc - 1) tick();
            checkOutput($sformatf("vec%0d_ready", i), {7'd0, bus.ready_o}, {7'd0, vecs[i].ready});
            checkOutput($sformatf("vec%0d_sel", i),   {7'd0, bus.input_select_o}, {7'd0, vecs[i].sel});
            checkOutput($sformatf("vec%0d_en", i),    {7'd0, bus.en_reg_state_o}, {7'd0, vecs[i].en});
            checkOutput($sformatf("vec%0d_busy", i),  {7'd0, bus.busy_o}, {7'd0, vecs[i].busy});
            checkOutput($sformatf("vec%0d_done", i),  {7'd0, bus.done_o}, {7'd0, vecs[i].done});
            if (vecs[i].round_care)
                checkOutput($sformatf("vec%0d_round", i), {4'd0, bus.round_o}, {4'd0, vecs[i].round});
            waitReady();
        end

        // Full p^a sequence: select only in cycle 1, rounds 0..11, done in 13.
        startRun(1'b1);
        for (int c = 1; c <= 14; c++) begin
            if (c <= 12) begin
                checkOutput($sformatf("pa_c%0d_round", c), {4'd0, bus.round_o}, 8'(c - 1));
                checkOutput($sformatf("pa_c%0d_sel", c), {7'd0, bus.input_select_o}, (c == 1) ? 8'd1 : 8'd0);
                checkOutput($sformatf("pa_c%0d_en", c), {7'd0, bus.en_reg_state_o}, 8'd1);
            end
            checkOutput($sformatf("pa_c%0d_done", c), {7'd0, bus.done_o}, (c == 13) ? 8'd1 : 8'd0);
            checkOutput($sformatf("pa_c%0d_ready", c), {7'd0, bus.ready_o}, (c == 14) ? 8'd1 : 8'd0);
            tick();
        end
        waitReady();

        // Starts during RUN and DONE with a toggling mode are ignored.
        startRun(1'b0);
        tick();
        checkOutput("ign_c2_round", {4'd0, bus.round_o}, 8'd7);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("ign_c3_round", {4'd0, bus.round_o}, 8'd8);
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("ign_c4_round", {4'd0, bus.round_o}, 8'd9);
        checkOutput("ign_c4_sel",   {7'd0, bus.input_select_o}, 8'd0);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("ign_c5_round", {4'd0, bus.round_o}, 8'd10);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("ign_c6_round", {4'd0, bus.round_o}, 8'd11);
        tick();
        checkOutput("ign_c7_done", {7'd0, bus.done_o}, 8'd1);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("ign_c8_ready", {7'd0, bus.ready_o}, 8'd1);
        tick();
        checkOutput("ign_c9_ready", {7'd0, bus.ready_o}, 8'd1);
        checkOutput("ign_c9_busy",  {7'd0, bus.busy_o}, 8'd0);

        // Asynchronous reset in the middle of a p^a run.
        startRun(1'b1);
        repeat (8) tick();
        checkOutput("rst_pre_round", {4'd0, bus.round_o}, 8'd8);
        resetb = 1'b0;
        #1;
        checkOutput("rst_ready", {7'd0, bus.ready_o}, 8'd1);
        checkOutput("rst_busy",  {7'd0, bus.busy_o}, 8'd0);
        checkOutput("rst_done",  {7'd0, bus.done_o}, 8'd0);
        checkOutput("rst_round", {4'd0, bus.round_o}, 8'd0);
        tick();
        resetb = 1'b1;
        tick();
        startRun(1'b0);
        checkOutput("rst_after_round", {4'd0, bus.round_o}, 8'd6);
        repeat (6) tick();
        checkOutput("rst_after_done", {7'd0, bus.done_o}, 8'd1);
        waitReady();

        // Back-to-back: start held high, p^a then p^b.
        done1 = 8'd0;
        done2 = 8'd0;
        applyStimulus(1'b1, 1'b1);
        for (int c = 1; c <= 40 && done2 == 8'd0; c++) begin
            tick();
            if (c == 15) begin
                checkOutput("b2b_c15_sel",   {7'd0, bus.input_select_o}, 8'd1);
                checkOutput("b2b_c15_round", {4'd0, bus.round_o}, 8'd6);
            end
            if (bus.done_o) begin
                if (done1 == 8'd0) done1 = 8'(c);
                else               done2 = 8'(c);
            end
            if (done1 != 8'd0) bus.mode_i = 1'b0;
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("b2b_done_pa", done1, 8'd13);
        checkOutput("b2b_done_pb", done2, 8'd21);
        waitReady();

        // ROUNDS_B = 1: single round at index 11, done in cycle 2.
        bus_b1.start_i = 1'b1;
        bus_b1.mode_i  = 1'b0;
        tick();
        bus_b1.start_i = 1'b0;
        checkOutput("b1_c1_round", {4'd0, bus_b1.round_o}, 8'd11);
        checkOutput("b1_c1_sel",   {7'd0, bus_b1.input_select_o}, 8'd1);
        checkOutput("b1_c1_busy",  {7'd0, bus_b1.busy_o}, 8'd1);
        tick();
        checkOutput("b1_c2_done",  {7'd0, bus_b1.done_o}, 8'd1);
        checkOutput("b1_c2_busy",  {7'd0, bus_b1.busy_o}, 8'd0);
        tick();
        checkOutput("b1_c3_ready", {7'd0, bus_b1.ready_o}, 8'd1);
        checkOutput("b1_c3_done",  {7'd0, bus_b1.done_o}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
